// File: rtl/xadac_pkg.sv
// Shared types for the xadac issue path: request/response payloads, scoreboard
// counter width and the issue-stage state enum.
package xadac_pkg;

  localparam int SbLen  = 16;
  localparam int NoRs   = 2;
  localparam int NoVs   = 3;
  localparam int NoVec  = 32;
  localparam int VecLen = 64;

  typedef logic [3:0]                 IdT;
  typedef logic [31:0]                InstrT;
  typedef logic [4:0]                 RegAddrT;
  typedef logic [31:0]                RegDataT;
  typedef logic [$clog2(NoVec)-1:0]   VecAddrT;
  typedef logic [VecLen-1:0]          VecDataT;
  typedef logic [$clog2(SbLen+1)-1:0] ScbCntT;

  typedef enum logic [1:0] {
    ISSUE_EMPTY,
    ISSUE_STALL,
    ISSUE_VALID
  } IssueStateT;

  typedef struct packed {
    IdT                  id;
    InstrT               instr;
    RegAddrT [NoRs-1:0]  rs_addr;
    RegDataT [NoRs-1:0]  rs_data;
    VecAddrT [NoVs-1:0]  vs_addr;
    VecDataT [NoVs-1:0]  vs_data;
  } ExeReqT;

  typedef struct packed {
    IdT      id;
    RegDataT rd_data;
    logic    rd_write;
    RegAddrT rd_addr;
    VecDataT vd_data;
    logic    vd_write;
    VecAddrT vd_addr;
  } ExeRspT;

  // RAW on any read source or WAW on the destination against a busy table.
  function automatic logic vec_hazard(input logic [NoVs-1:0]   vs_read,
                                      input VecAddrT [NoVs-1:0] vs_addr,
                                      input logic               vd_clobber,
                                      input VecAddrT            vd_addr,
                                      input logic [NoVec-1:0]   busy);
    logic h;
    h = vd_clobber & busy[vd_addr];
    for (int k = 0; k < NoVs; k++) begin
      if (vs_read[k] && busy[vs_addr[k]]) h = 1'b1;
    end
    return h;
  endfunction

endpackage

// File: rtl/xadac_vec_busy.sv
// Per-vector-register pending-write table; a set and a clear to the same
// register in one cycle leaves it busy.
module xadac_vec_busy
  import xadac_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             set_i,
  input  VecAddrT          set_addr_i,
  input  logic             clr_i,
  input  VecAddrT          clr_addr_i,
  output logic [NoVec-1:0] busy_o
);

  logic [NoVec-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_addr_i] = 1'b0;
    if (set_i) busy_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/xadac_issue_ctrl.sv
// Single-entry issue stage that holds a request until its vector operands are
// free of pending writes and the outstanding-response budget allows issue.
module xadac_issue_ctrl
  import xadac_pkg::*;
#(
  parameter int MaxOutstanding = SbLen
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  ExeReqT           req_i,
  input  logic [NoVs-1:0]  req_vs_read_i,
  input  logic             req_vd_clobber_i,
  input  VecAddrT          req_vd_addr_i,
  output logic             exe_valid_o,
  input  logic             exe_ready_i,
  output ExeReqT           exe_o,
  input  logic             rsp_valid_i,
  input  ExeRspT           rsp_i,
  output logic [NoVec-1:0] vec_busy_o,
  output ScbCntT           outstanding_o,
  output logic             err_o
);

  localparam ScbCntT MaxCnt   = ScbCntT'(MaxOutstanding);
  localparam ScbCntT MaxCntM1 = ScbCntT'(MaxOutstanding - 1);

  IssueStateT       state_q, state_d;
  ExeReqT           req_q;
  logic [NoVs-1:0]  vs_read_q;
  logic             vd_clobber_q;
  VecAddrT          vd_addr_q;
  ScbCntT           cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [NoVec-1:0] busy, busy_after;
  logic             handshake, capture, set_fire, clr_fire;
  logic             stall_hazard, cap_hazard;
  logic             unused_rsp;

  assign unused_rsp = ^{rsp_i.id, rsp_i.rd_data, rsp_i.rd_write, rsp_i.rd_addr, rsp_i.vd_data};

  assign exe_valid_o = (state_q == ISSUE_VALID);
  assign handshake   = exe_valid_o & exe_ready_i;
  assign req_ready_o = ~rst_i & ((state_q == ISSUE_EMPTY) | handshake);
  assign capture     = req_valid_i & req_ready_o;
  assign set_fire    = handshake & vd_clobber_q;
  assign clr_fire    = rsp_valid_i & rsp_i.vd_write;

  xadac_vec_busy u_vec_busy (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_i      (set_fire),
    .set_addr_i (vd_addr_q),
    .clr_i      (clr_fire),
    .clr_addr_i (rsp_i.vd_addr),
    .busy_o     (busy)
  );

  // A request captured alongside an issue must see the write that issue marks
  // busy and the count it adds; responses this cycle are only seen next cycle.
  always_comb begin
    busy_after = busy;
    if (set_fire) busy_after[vd_addr_q] = 1'b1;
  end

  assign stall_hazard = vec_hazard(vs_read_q, req_q.vs_addr, vd_clobber_q, vd_addr_q, busy)
                        | (cnt_q >= MaxCnt);
  assign cap_hazard   = vec_hazard(req_vs_read_i, req_i.vs_addr, req_vd_clobber_i,
                                   req_vd_addr_i, busy_after)
                        | (handshake ? (cnt_q >= MaxCntM1) : (cnt_q >= MaxCnt));

  always_comb begin
    state_d = state_q;
    if (capture) begin
      state_d = cap_hazard ? ISSUE_STALL : ISSUE_VALID;
    end else if (state_q == ISSUE_STALL && !stall_hazard) begin
      state_d = ISSUE_VALID;
    end else if (handshake) begin
      state_d = ISSUE_EMPTY;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (handshake && !rsp_valid_i) begin
      cnt_d = cnt_q + ScbCntT'(1);
    end else if (!handshake && rsp_valid_i && cnt_q != '0) begin
      cnt_d = cnt_q - ScbCntT'(1);
    end
    if (rsp_valid_i && cnt_q == '0) err_d = 1'b1;
    if (clr_fire && !busy[rsp_i.vd_addr]) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ISSUE_EMPTY;
      req_q        <= '0;
      vs_read_q    <= '0;
      vd_clobber_q <= 1'b0;
      vd_addr_q    <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (capture) begin
        req_q        <= req_i;
        vs_read_q    <= req_vs_read_i;
        vd_clobber_q <= req_vd_clobber_i;
        vd_addr_q    <= req_vd_addr_i;
      end
    end
  end

  assign exe_o         = req_q;
  assign vec_busy_o    = busy;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_xadac_issue_ctrl.sv
// Directed and randomized checks of xadac_issue_ctrl against a transaction-level
// model of the hazard, counting and error rules.
module tb_xadac_issue_ctrl;
  import xadac_pkg::*;

  localparam int MaxOut = 16;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req_valid_i;
  logic             req_ready_o;
  ExeReqT           req_i;
  logic [NoVs-1:0]  req_vs_read_i;
  logic             req_vd_clobber_i;
  VecAddrT          req_vd_addr_i;
  logic             exe_valid_o;
  logic             exe_ready_i;
  ExeReqT           exe_o;
  logic             rsp_valid_i;
  ExeRspT           rsp_i;
  logic [NoVec-1:0] vec_busy_o;
  ScbCntT           outstanding_o;
  logic             err_o;

  always #5 clk_i = ~clk_i;

  xadac_issue_ctrl #(.MaxOutstanding(MaxOut)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_i(req_i),
    .req_vs_read_i(req_vs_read_i), .req_vd_clobber_i(req_vd_clobber_i),
    .req_vd_addr_i(req_vd_addr_i),
    .exe_valid_o(exe_valid_o), .exe_ready_i(exe_ready_i), .exe_o(exe_o),
    .rsp_valid_i(rsp_valid_i), .rsp_i(rsp_i),
    .vec_busy_o(vec_busy_o), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  int vectors = 0;
  int miscompares = 0;
  int issue_seen = 0;

  // Model: the held request, whether it is cleared to issue, and scoreboard.
  bit              m_have, m_ok, m_clob;
  ExeReqT          m_req;
  logic [NoVs-1:0] m_vs_read;
  int              m_vd;
  bit              m_busy[NoVec];
  int              m_cnt;
  bit              m_err;
  int              issue_log[$];

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NoVec-1:0] pack_busy();
    logic [NoVec-1:0] v;
    for (int i = 0; i < NoVec; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic bit blocked(input logic [NoVs-1:0] rd, input ExeReqT r, input bit clob,
                                 input int vd, input logic [NoVec-1:0] b, input int cnt);
    bit h;
    h = (cnt >= MaxOut);
    for (int k = 0; k < NoVs; k++) if (rd[k] && b[r.vs_addr[k]]) h = 1;
    if (clob && b[vd]) h = 1;
    return h;
  endfunction

  task automatic model_reset();
    m_have = 0; m_ok = 0; m_clob = 0; m_req = '0; m_vs_read = '0; m_vd = 0;
    for (int i = 0; i < NoVec; i++) m_busy[i] = 0;
    m_cnt = 0; m_err = 0;
    issue_log.delete();
  endtask

  // Compare at the falling edge, then advance the model across the rising edge.
  task automatic tick();
    bit ev, er, issue, cap, old_clob;
    int old_vd, c_after;
    logic [NoVec-1:0] b_after;
    @(negedge clk_i);
    ev = !rst_i && m_have && m_ok;
    er = !rst_i && (!m_have || (ev && exe_ready_i));
    check("exe_valid", exe_valid_o, ev);
    check("req_ready", req_ready_o, er);
    if (ev) check("exe_payload", exe_o, m_req);
    check("vec_busy", vec_busy_o, pack_busy());
    check("outstanding", outstanding_o, m_cnt);
    check("err", err_o, m_err);
    if (exe_valid_o && exe_ready_i) issue_seen++;
    @(posedge clk_i);
    if (rst_i) begin
      model_reset();
    end else begin
      issue = ev && exe_ready_i;
      cap = req_valid_i && er;
      old_clob = m_clob;
      old_vd = m_vd;
      if (issue) issue_log.push_back(old_clob ? old_vd : -1);
      b_after = pack_busy();
      c_after = m_cnt;
      if (issue) begin
        if (old_clob) b_after[old_vd] = 1;
        c_after++;
      end
      if (cap) begin
        m_have = 1; m_req = req_i; m_vs_read = req_vs_read_i;
        m_clob = req_vd_clobber_i; m_vd = int'(req_vd_addr_i);
        m_ok = !blocked(m_vs_read, m_req, m_clob, m_vd, b_after, c_after);
      end else if (m_have && !m_ok) begin
        m_ok = !blocked(m_vs_read, m_req, m_clob, m_vd, pack_busy(), m_cnt);
      end else if (issue) begin
        m_have = 0;
      end
      if (rsp_valid_i) begin
        if (m_cnt == 0) m_err = 1;
        if (rsp_i.vd_write) begin
          if (!m_busy[rsp_i.vd_addr]) m_err = 1;
          m_busy[rsp_i.vd_addr] = 0;
        end
      end
      if (issue && old_clob) m_busy[old_vd] = 1;
      if (issue && !rsp_valid_i) m_cnt++;
      else if (!issue && rsp_valid_i && m_cnt > 0) m_cnt--;
    end
    #1;
  endtask

  task automatic applyStimulus(input logic [NoVs-1:0] mask, input int vs0, input bit clob,
                               input int vd);
    req_valid_i = 1;
    req_i = '0;
    req_i.id = IdT'($urandom);
    req_i.instr = $urandom;
    for (int k = 0; k < NoRs; k++) begin
      req_i.rs_addr[k] = RegAddrT'($urandom);
      req_i.rs_data[k] = $urandom;
    end
    for (int k = 0; k < NoVs; k++) begin
      req_i.vs_addr[k] = VecAddrT'($urandom_range(0, 7));
      req_i.vs_data[k] = {$urandom, $urandom};
    end
    if (vs0 >= 0) req_i.vs_addr[0] = VecAddrT'(vs0);
    req_vs_read_i = mask;
    req_vd_clobber_i = clob;
    req_vd_addr_i = VecAddrT'(vd);
  endtask

  task automatic req_idle();
    req_valid_i = 0;
  endtask

  task automatic rsp_from_log();
    int v;
    rsp_valid_i = 0;
    if (issue_log.size() > 0) begin
      v = issue_log.pop_front();
      rsp_i = '0;
      rsp_i.id = IdT'($urandom);
      rsp_i.vd_data = {$urandom, $urandom};
      rsp_i.vd_write = (v >= 0);
      rsp_i.vd_addr = VecAddrT'((v >= 0) ? v : 0);
      rsp_valid_i = 1;
    end
  endtask

  task automatic rsp_idle();
    rsp_valid_i = 0;
    rsp_i = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && issue_log.size() > 0; i++) begin
      rsp_from_log(); tick();
    end
    rsp_idle(); tick();
  endtask

  task automatic do_reset();
    rst_i = 1; model_reset(); tick(); tick();
    rst_i = 0;
  endtask

  initial begin
    ExeReqT held;
    rst_i = 1; req_valid_i = 0; req_i = '0; req_vs_read_i = '0; req_vd_clobber_i = 0;
    req_vd_addr_i = '0; exe_ready_i = 0; rsp_valid_i = 0; rsp_i = '0;
    model_reset();
    do_reset();
    exe_ready_i = 1;

    $display("[TB] back-to-back independent requests");
    issue_seen = 0;
    for (int i = 0; i < 4; i++) begin applyStimulus('0, -1, 1, 10 + i); tick(); end
    req_idle(); tick();
    check("b2b_outstanding", outstanding_o, 4);
    check("b2b_issues", issue_seen, 4);
    drain();

    $display("[TB] read-after-write stall");
    applyStimulus('0, -1, 1, 3); tick();
    applyStimulus(3'b001, 3, 0, 0); tick();
    req_idle(); tick(); tick(); tick();
    check("raw_stalled", exe_valid_o, 0);
    rsp_from_log(); tick(); rsp_idle(); tick(); tick(); tick();
    check("raw_released_busy", vec_busy_o[3], 0);
    drain();

    $display("[TB] write-after-write stall");
    applyStimulus('0, -1, 1, 7); tick();
    applyStimulus('0, -1, 1, 7); tick();
    req_idle(); tick(); tick(); tick();
    check("waw_stalled", exe_valid_o, 0);
    check("waw_busy7", vec_busy_o[7], 1);
    rsp_from_log(); tick(); rsp_idle(); tick(); tick(); tick();
    check("waw_second_busy7", vec_busy_o[7], 1);
    drain();

    $display("[TB] outstanding limit");
    for (int i = 0; i < 17; i++) begin applyStimulus('0, -1, 0, 0); tick(); end
    req_idle(); tick(); tick(); tick();
    check("limit_count", outstanding_o, 16);
    check("limit_stalled", exe_valid_o, 0);
    rsp_from_log(); tick(); rsp_idle(); tick(); tick();
    check("limit_refill", outstanding_o, 16);
    drain();

    $display("[TB] backpressure");
    exe_ready_i = 0;
    applyStimulus('0, -1, 1, 20); held = req_i; tick();
    applyStimulus('0, -1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_payload", exe_o, held);
      check("bp_ready", req_ready_o, 0);
    end
    exe_ready_i = 1; tick(); req_idle(); tick(); tick();
    drain();

    $display("[TB] protocol errors and reset mid-stall");
    rsp_valid_i = 1; rsp_i = '0; tick(); rsp_idle(); tick();
    check("err_underflow", err_o, 1);
    check("err_count_floor", outstanding_o, 0);
    do_reset(); tick();
    applyStimulus('0, -1, 1, 5); tick();
    applyStimulus(3'b001, 5, 1, 6); tick();
    req_idle(); tick();
    check("stall_before_reset", exe_valid_o, 0);
    #2 rst_i = 1;
    #1;
    check("rst_exe_valid", exe_valid_o, 0);
    check("rst_req_ready", req_ready_o, 0);
    check("rst_busy", vec_busy_o, 0);
    check("rst_outstanding", outstanding_o, 0);
    check("rst_err", err_o, 0);
    check("rst_exe_o", exe_o, 0);
    model_reset();
    tick();
    rst_i = 0;
    applyStimulus('0, -1, 0, 0); tick();
    req_idle(); tick(); tick();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      exe_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 7)
        applyStimulus(NoVs'($urandom), -1, 1'($urandom), $urandom_range(0, 7));
      else
        req_idle();
      if (issue_log.size() > 0 && $urandom_range(0, 2) == 0) rsp_from_log();
      else rsp_idle();
      tick();
    end
    req_idle(); exe_ready_i = 1; rsp_idle();
    for (int i = 0; i < 4; i++) tick();
    drain(); drain();
    check("final_err", err_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xadac_issue_ctrl.md
XADAC_ISSUE_CTRL -- requirements
Module: xadac_issue_ctrl

Interface
REQ-001 SHALL have parameter MaxOutstanding, default SbLen (16), giving the maximum number of issued instructions still awaiting a response.
REQ-002 SHALL have port clk_i  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid_i  in  1  execute request valid.
REQ-005 SHALL have port req_ready_o  out  1  execute request accepted.
REQ-006 SHALL have port req_i  in  ExeReqT  request payload (id, instr, rs/vs addr+data).
REQ-007 SHALL have port req_vs_read_i  in  NoVs  per-source mask of vector sources actually read.
REQ-008 SHALL have port req_vd_clobber_i  in  1  instruction writes a vector register.
REQ-009 SHALL have port req_vd_addr_i  in  VecAddrT  destination vector register.
REQ-010 SHALL have port exe_valid_o  out  1  issue to execution unit valid.
REQ-011 SHALL have port exe_ready_i  in  1  execution unit accepts.
REQ-012 SHALL have port exe_o  out  ExeReqT  issued payload.
REQ-013 SHALL have port rsp_valid_i  in  1  execution unit response (always accepted).
REQ-014 SHALL have port rsp_i  in  ExeRspT  response payload; only vd_write, vd_addr used.
REQ-015 SHALL have port vec_busy_o  out  NoVec  per-vector-register pending-write bit.
REQ-016 SHALL have port outstanding_o  out  ScbCntT  issued-not-responded count.
REQ-017 SHALL have port err_o  out  1  sticky protocol error.

Function
REQ-018 SHALL hold one request in a stage register with states EMPTY, STALL, VALID.
REQ-019 SHALL drive req_ready_o = (state==EMPTY) or (exe_valid_o and exe_ready_i), giving one issue per cycle at full throughput.
REQ-020 SHALL, on req handshake, capture req_i, req_vs_read_i, req_vd_clobber_i and req_vd_addr_i; exe_valid_o rises one cycle later at the earliest.
REQ-021 SHALL define hazard = any k with vs_read[k] and busy[vs_addr[k]] (RAW), or vd_clobber and busy[vd_addr] (WAW), or outstanding==MaxOutstanding.
REQ-022 SHALL evaluate the hazard on registered busy/count state, so a response clears a hazard with one cycle of latency.
REQ-023 SHALL enter VALID from a capture or from STALL when there is no hazard, and STALL otherwise.
REQ-024 SHALL never leave VALID except by exe handshake, keeping exe_o stable while exe_valid_o=1 and exe_ready_i=0.
REQ-025 SHALL, on exe handshake, set busy[vd_addr] if vd_clobber, increment outstanding, then go to EMPTY, or stay in VALID/STALL if a new request is captured in the same cycle.
REQ-026 SHALL, on rsp_valid_i, decrement outstanding and clear busy[rsp_i.vd_addr] when rsp_i.vd_write=1.
REQ-027 SHALL net increment and decrement in the same cycle to no change.
REQ-028 SHALL let set win over clear when both target the same register in the same cycle.
REQ-029 SHALL, on rsp_valid_i with outstanding==0, leave the count at 0 and set err_o until reset.
REQ-030 SHALL set err_o if a clear hits a register that is not busy.

Reset
REQ-031 SHALL on rst_i assertion, at any time including mid-stall, immediately force state=EMPTY, exe_valid_o=0, req_ready_o=0 while asserted, vec_busy_o=0, outstanding_o=0, err_o=0 and exe_o=0.
REQ-032 SHALL accept requests the first cycle after rst_i deasserts.

Structure
REQ-033 SHALL add ScbCntT (logic [$clog2(SbLen+1)-1:0]) and the IssueStateT enum to xadac_pkg.
REQ-034 SHALL place the busy table in sub-module xadac_vec_busy (NoVec bits, set port, clear port, set-wins priority).

Verification
REQ-035 SHALL verify back-to-back independent requests with exe_ready_i=1: 4 requests issue on 4 consecutive cycles and outstanding_o reaches 4.
REQ-036 SHALL verify RAW: issue vd=3, then a request with vs_read[0] and vs_addr[0]=3, which stalls until rsp vd_write vd_addr=3 and issues the cycle after.
REQ-037 SHALL verify WAW: two requests writing vd=7, where the second issues only after the first's response clears busy[7].
REQ-038 SHALL verify limit: 16 issued with no responses leaves the 17th in STALL; one rsp releases it the following cycle.
REQ-039 SHALL verify backpressure: exe_ready_i=0 for 5 cycles leaves exe_o unchanged and req_ready_o=0.
REQ-040 SHALL verify errors: rsp with outstanding=0 sets err_o, and rst_i mid-STALL clears all outputs asynchronously.
